// File: rtl/ring_phase_monitor_pkg.sv
// Shared types for the ring phase monitor: FSM states and error cause codes.
package ring_phase_monitor_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_ONEHOT = 2'd1;
  localparam logic [1:0] ERR_JUMP   = 2'd2;
  localparam logic [1:0] ERR_EN     = 2'd3;

endpackage

// File: rtl/ring_phase_monitor_onehot_encoder.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
module onehot_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] phase,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  // OR of set-bit positions; only meaningful when is_onehot is high.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (phase[i]) idx = idx | IDX_W'(i);
    end
    is_onehot = ($countones(phase) == 1);
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors a one-hot ring counter: binary index, rotation count, and sticky
// legality checking with a first-cause error code.
module ring_phase_monitor
  import ring_phase_monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int CHECK_EN = 1,
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] phase,
  input  logic             phase_en,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             wrap,
  output logic [CNT_W-1:0] rot_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output state_t           state_dbg
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] phase_q;
  logic             en_q;
  logic [IDX_W-1:0] enc_idx;
  logic             is_onehot;
  logic             is_step, is_hold;
  logic [1:0]       fault_code;

  logic [IDX_W-1:0] idx_nx;
  logic             idx_valid_nx, wrap_nx, err_nx;
  logic [CNT_W-1:0] rot_cnt_nx;
  logic [1:0]       err_code_nx;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .phase     (phase),
    .idx       (enc_idx),
    .is_onehot (is_onehot)
  );

  // For WIDTH=2 rotate-left equals rotate-right, so either direction is a step.
  assign is_step = (phase == {phase_q[WIDTH-2:0], phase_q[WIDTH-1]});
  assign is_hold = (phase == phase_q);
  assign state_dbg = state;

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    idx_valid_nx = idx_valid;
    wrap_nx      = 1'b0;
    rot_cnt_nx   = rot_cnt;
    err_nx       = err;
    err_code_nx  = err_code;
    fault_code   = ERR_NONE;
    case (state)
      SYNC: begin
        if (phase == '0) begin
          state_nx = SYNC;
        end else if (is_onehot) begin
          state_nx     = TRACK;
          idx_nx       = enc_idx;
          idx_valid_nx = 1'b1;
        end else begin
          fault_code = ERR_ONEHOT;
        end
      end
      TRACK: begin
        if (!is_onehot) begin
          fault_code = ERR_ONEHOT;
        end else if (!is_hold && !is_step) begin
          fault_code = ERR_JUMP;
        end else if ((CHECK_EN != 0) && (is_step ^ en_q)) begin
          fault_code = ERR_EN;
        end else begin
          idx_nx = enc_idx;
          if (is_step && phase_q[WIDTH-1]) begin
            wrap_nx    = 1'b1;
            rot_cnt_nx = rot_cnt + CNT_W'(1);
          end
        end
      end
      ERR: begin
        if (clr_err) begin
          state_nx    = SYNC;
          err_nx      = 1'b0;
          err_code_nx = ERR_NONE;
        end
      end
      default: state_nx = SYNC;
    endcase
    // A detected fault overrides everything, including a same-cycle clr_err.
    if (fault_code != ERR_NONE) begin
      state_nx     = ERR;
      err_nx       = 1'b1;
      err_code_nx  = fault_code;
      idx_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      phase_q   <= '0;
      en_q      <= 1'b0;
      idx       <= '0;
      idx_valid <= 1'b0;
      wrap      <= 1'b0;
      rot_cnt   <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nx;
      phase_q   <= phase;
      en_q      <= phase_en;
      idx       <= idx_nx;
      idx_valid <= idx_valid_nx;
      wrap      <= wrap_nx;
      rot_cnt   <= rot_cnt_nx;
      err       <= err_nx;
      err_code  <= err_code_nx;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: two instances (CHECK_EN=1 and 0) share inputs
// and are compared against a position-based reference model.
module tb_ring_phase_monitor;
  import ring_phase_monitor_pkg::*;

  localparam int M_SYNC = 0, M_TRACK = 1, M_ERR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] phase = '0;
  logic       phase_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [2:0] d_idx [2];
  logic       d_vld [2];
  logic       d_wrap [2];
  logic [7:0] d_rot [2];
  logic       d_err [2];
  logic [1:0] d_code [2];
  state_t     d_state [2];
  logic [15:0] obs [2];

  int m_mode [2];
  logic [7:0] m_pq [2];
  bit m_eq [2];
  logic [2:0] m_idx [2];
  bit m_vld [2];
  bit m_wrap [2];
  logic [7:0] m_rot [2];
  bit m_err [2];
  logic [1:0] m_code [2];

  int n_vec = 0;
  int n_mis = 0;
  logic [7:0] rc = '0;

  always #5 clk = ~clk;

  ring_phase_monitor #(.WIDTH(8), .CNT_W(8), .CHECK_EN(1)) dut_a (
    .clk(clk), .rst(rst), .phase(phase), .phase_en(phase_en), .clr_err(clr_err),
    .idx(d_idx[0]), .idx_valid(d_vld[0]), .wrap(d_wrap[0]), .rot_cnt(d_rot[0]),
    .err(d_err[0]), .err_code(d_code[0]), .state_dbg(d_state[0])
  );

  ring_phase_monitor #(.WIDTH(8), .CNT_W(8), .CHECK_EN(0)) dut_b (
    .clk(clk), .rst(rst), .phase(phase), .phase_en(phase_en), .clr_err(clr_err),
    .idx(d_idx[1]), .idx_valid(d_vld[1]), .wrap(d_wrap[1]), .rot_cnt(d_rot[1]),
    .err(d_err[1]), .err_code(d_code[1]), .state_dbg(d_state[1])
  );

  assign obs[0] = {d_idx[0], d_vld[0], d_wrap[0], d_rot[0], d_err[0], d_code[0]};
  assign obs[1] = {d_idx[1], d_vld[1], d_wrap[1], d_rot[1], d_err[1], d_code[1]};

  // ---------------- reference model ----------------
  function automatic int pos_of(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ring_next(logic [7:0] v);
    return (v == 8'h00) ? 8'h01 : {v[6:0], v[7]};
  endfunction

  function automatic logic [15:0] exp_pack(int k);
    return {m_idx[k], m_vld[k], m_wrap[k], m_rot[k], m_err[k], m_code[k]};
  endfunction

  function automatic void model_edge(int k, bit ce, logic [7:0] ph, bit en, bit clr, bit r);
    int p, pp;
    bit stepped;
    logic [1:0] c;
    if (r) begin
      m_mode[k] = M_SYNC; m_pq[k] = '0; m_eq[k] = 0; m_idx[k] = '0; m_vld[k] = 0;
      m_wrap[k] = 0; m_rot[k] = '0; m_err[k] = 0; m_code[k] = '0;
      return;
    end
    p  = ($countones(ph) == 1) ? pos_of(ph) : -1;
    pp = pos_of(m_pq[k]);
    m_wrap[k] = 0;
    c = 2'd0;
    case (m_mode[k])
      M_SYNC: begin
        if (ph != 8'h00) begin
          if (p < 0) c = 2'd1;
          else begin
            m_mode[k] = M_TRACK; m_idx[k] = p[2:0]; m_vld[k] = 1;
          end
        end
      end
      M_TRACK: begin
        stepped = (p >= 0) && (p == (pp + 1) % 8);
        if (p < 0) c = 2'd1;
        else if (p != pp && !stepped) c = 2'd2;
        else if (ce && (stepped != m_eq[k])) c = 2'd3;
        else begin
          m_idx[k] = p[2:0];
          if (stepped && pp == 7) begin
            m_wrap[k] = 1;
            m_rot[k]  = m_rot[k] + 8'd1;
          end
        end
      end
      default: begin
        if (clr) begin
          m_mode[k] = M_SYNC; m_err[k] = 0; m_code[k] = 2'd0;
        end
      end
    endcase
    if (c != 2'd0) begin
      m_mode[k] = M_ERR; m_err[k] = 1; m_code[k] = c; m_vld[k] = 0;
    end
    m_pq[k] = ph;
    m_eq[k] = en;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic [7:0] ph, input bit en, input bit clr, input bit r);
    @(negedge clk);
    phase = ph; phase_en = en; clr_err = clr; rst = r;
    @(posedge clk);
    model_edge(0, 1'b1, ph, en, clr, r);
    model_edge(1, 1'b0, ph, en, clr, r);
    #1;
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b0, 1'b1);
    rc = 8'h00;
  endtask

  // Drives the ring-counter model until target is sampled, with last_en on that cycle.
  task automatic walk_to(input logic [7:0] target, input bit last_en);
    for (int i = 0; i < 16; i++) begin
      if (rc == target) begin
        step(rc, last_en, 1'b0, 1'b0);
        if (last_en) rc = ring_next(rc);
        return;
      end
      step(rc, 1'b1, 1'b0, 1'b0);
      rc = ring_next(rc);
    end
    n_vec++; n_mis++;
    $display("FAIL walk_to: target %h never reached, ring at %h", target, rc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(8'h5a, 1'b1, 1'b1, 1'b1);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== 16'h0000 || d_state[k] !== SYNC) begin
        n_mis++;
        $display("FAIL reset inst%0d: got %h state %0d, want 0000 state SYNC", k, obs[k], d_state[k]);
      end
    end
  endtask

  task automatic test_walk();
    int wraps = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(rc, 1'b1, 1'b0, 1'b0);
      rc = ring_next(rc);
      if (d_wrap[0]) wraps++;
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_pack(k)) begin
          n_mis++;
          $display("FAIL walk inst%0d cyc%0d: got %h want %h", k, c, obs[k], exp_pack(k));
        end
      end
    end
    n_vec++;
    if (wraps != 1 || d_rot[0] !== 8'd1 || d_idx[0] !== 3'd2 || d_vld[0] !== 1'b1) begin
      n_mis++;
      $display("FAIL walk_end: wraps %0d rot %0d idx %0d vld %b, want 1 1 2 1",
               wraps, d_rot[0], d_idx[0], d_vld[0]);
    end
  endtask

  task automatic test_rotations();
    int wraps = 0;
    int cyc = 0;
    bit en;
    do_reset();
    while (wraps < 256 && cyc < 10000) begin
      en = ($urandom_range(0, 3) != 0);
      step(rc, en, 1'b0, 1'b0);
      if (en) rc = ring_next(rc);
      cyc++;
      if (d_wrap[0]) wraps++;
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs[k] !== exp_pack(k)) begin
          n_mis++;
          $display("FAIL rotations inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_pack(k));
        end
      end
    end
    n_vec++;
    if (wraps != 256 || d_rot[0] !== 8'd0 || d_rot[1] !== 8'd0) begin
      n_mis++;
      $display("FAIL rot_wrap: wraps %0d rot %0d/%0d, want 256 0/0", wraps, d_rot[0], d_rot[1]);
    end
  endtask

  task automatic test_not_onehot();
    do_reset();
    walk_to(8'h08, 1'b1);
    n_vec++;
    if (d_idx[0] !== 3'd3 || d_vld[0] !== 1'b1) begin
      n_mis++;
      $display("FAIL onehot_pre: idx %0d vld %b, want 3 1", d_idx[0], d_vld[0]);
    end
    step(8'h18, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_err[k] !== 1'b1 || d_code[k] !== 2'd1 || d_vld[k] !== 1'b0 || d_idx[k] !== 3'd3) begin
        n_mis++;
        $display("FAIL onehot inst%0d: err %b code %0d vld %b idx %0d, want 1 1 0 3",
                 k, d_err[k], d_code[k], d_vld[k], d_idx[k]);
      end
    end
    step(8'h40, 1'b1, 1'b0, 1'b0);
    step(8'h03, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (d_code[0] !== 2'd1 || d_err[0] !== 1'b1 || obs[0] !== exp_pack(0)) begin
      n_mis++;
      $display("FAIL onehot_sticky: got %h code %0d, want %h code 1", obs[0], d_code[0], exp_pack(0));
    end
  endtask

  task automatic test_jump();
    do_reset();
    walk_to(8'h04, 1'b1);
    step(8'h10, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_code[k] !== 2'd2 || d_err[k] !== 1'b1 || d_idx[k] !== 3'd2) begin
        n_mis++;
        $display("FAIL jump inst%0d: code %0d err %b idx %0d, want 2 1 2", k, d_code[k], d_err[k], d_idx[k]);
      end
    end
  endtask

  task automatic test_en_mismatch();
    do_reset();
    walk_to(8'h02, 1'b1);
    step(8'h02, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (d_code[0] !== 2'd3 || d_err[0] !== 1'b1 || d_vld[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL en_missed: code %0d err %b vld %b, want 3 1 0", d_code[0], d_err[0], d_vld[0]);
    end
    n_vec++;
    if (d_err[1] !== 1'b0 || d_vld[1] !== 1'b1 || d_idx[1] !== 3'd1) begin
      n_mis++;
      $display("FAIL en_missed_nochk: err %b vld %b idx %0d, want 0 1 1", d_err[1], d_vld[1], d_idx[1]);
    end
    do_reset();
    walk_to(8'h02, 1'b0);
    step(8'h04, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (d_code[0] !== 2'd3 || d_err[0] !== 1'b1) begin
      n_mis++;
      $display("FAIL en_spurious: code %0d err %b, want 3 1", d_code[0], d_err[0]);
    end
    n_vec++;
    if (d_err[1] !== 1'b0 || d_vld[1] !== 1'b1 || d_idx[1] !== 3'd2) begin
      n_mis++;
      $display("FAIL en_spurious_nochk: err %b vld %b idx %0d, want 0 1 2", d_err[1], d_vld[1], d_idx[1]);
    end
  endtask

  task automatic test_recovery();
    step(8'h00, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (d_err[0] !== 1'b0 || d_code[0] !== 2'd0 || d_state[0] !== SYNC) begin
      n_mis++;
      $display("FAIL clr: err %b code %0d state %0d, want 0 0 SYNC", d_err[0], d_code[0], d_state[0]);
    end
    step(8'h01, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (d_vld[0] !== 1'b1 || d_idx[0] !== 3'd0 || d_err[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL resync: vld %b idx %0d err %b, want 1 0 0", d_vld[0], d_idx[0], d_err[0]);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== exp_pack(k)) begin
        n_mis++;
        $display("FAIL recovery inst%0d: got %h want %h", k, obs[k], exp_pack(k));
      end
    end
  endtask

  task automatic test_rst_mid();
    int cyc = 0;
    do_reset();
    while (d_rot[0] !== 8'd5 && cyc < 200) begin
      step(rc, 1'b1, 1'b0, 1'b0);
      rc = ring_next(rc);
      cyc++;
    end
    step(rc, 1'b1, 1'b0, 1'b0);
    rc = ring_next(rc);
    step(rc, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (d_rot[0] !== 8'd5 || d_vld[0] !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_pre: rot %0d vld %b, want 5 1", d_rot[0], d_vld[0]);
    end
    step(ring_next(rc), 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs[k] !== 16'h0000 || d_state[k] !== SYNC) begin
        n_mis++;
        $display("FAIL rst_mid inst%0d: got %h state %0d, want 0000 SYNC", k, obs[k], d_state[k]);
      end
    end
  endtask

  task automatic test_clr_with_fault();
    do_reset();
    walk_to(8'h04, 1'b1);
    step(8'h40, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (d_err[k] !== 1'b1 || d_code[k] !== 2'd2 || d_state[k] !== ERR) begin
        n_mis++;
        $display("FAIL clr_vs_fault inst%0d: err %b code %0d, want 1 2", k, d_err[k], d_code[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_rotations();
    test_not_onehot();
    test_jump();
    test_en_mismatch();
    test_recovery();
    test_rst_mid();
    test_clr_with_fault();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
